// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART on the MEM-stage data bus.
// Registers: TXD (BASE+0x18), RXD (BASE+0x1C), CON (BASE+0x20).
// Optional macro UART_PARITY_EN adds an even-parity bit (11-bit frames)
// and the sticky CON[5] parity_err flag; without it CON[5] reads 0.
// dbg_tx_state / dbg_rx_state expose the two FSM state registers.
//
// Bus handshake: rd and wr are single-cycle strobes with no wait states.
// rdata is combinational from registers in the same cycle as rd. Side
// effects (register writes, clear-on-read) take place on the clock edge
// that ends the strobe cycle.
module uart_periph #(
    parameter logic [31:0] BASE     = 32'h4000_0000,
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [2:0]  dbg_tx_state,
    output logic [2:0]  dbg_rx_state
);

    localparam int unsigned   CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_e;

    // Address decode (full 32-bit compare)
    logic sel_txd, sel_rxd, sel_con;
    assign sel_txd = (addr == BASE + 32'h18);
    assign sel_rxd = (addr == BASE + 32'h1C);
    assign sel_con = (addr == BASE + 32'h20);

    logic wr_txd, wr_con, rd_rxd, rd_con;
    assign wr_txd = wr & sel_txd;
    assign wr_con = wr & sel_con;
    assign rd_rxd = rd & sel_rxd;
    assign rd_con = rd & sel_con;

    // Only the low byte of store data is ever used
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // Registers
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    txd_q, txd_d;
    logic          tx_line_q, tx_line_d;
    logic          tx_done_q, tx_done_d, tx_done_set;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rxd_q, rxd_d;
    logic          rx_ready_q, rx_ready_d, rx_set;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;

    logic [1:0]    con_ie_q, con_ie_d;
    logic          tx_busy;
    logic          parity_err;

    assign tx_busy = (tx_state_q != TX_IDLE);

    // TX FSM next state, frame sequencing and line value
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        txd_d       = txd_q;
        tx_done_set = 1'b0;
        tx_line_d   = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_txd) begin
                    txd_d      = wdata[7:0];
                    tx_shift_d = wdata[7:0];
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_line_d = 1'b0;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PAR;
`else
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            TX_PAR: begin
                // txd_q cannot change while busy, so it still holds the frame byte
                tx_line_d = ^txd_q;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_done_set = 1'b1;
                    tx_state_d  = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic par_err_set;
`endif

    // RX FSM: start validation at half bit, then mid-bit sampling
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rxd_d      = rxd_q;
        rx_set     = 1'b0;
`ifdef UART_PARITY_EN
        par_err_set = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    // A line that is high again here was a glitch
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PAR;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            RX_PAR: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q == ^rx_shift_q) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        par_err_set = 1'b1;
                        rx_state_d  = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    // Framing error (stop bit low) drops the byte silently
                    if (rx_s2_q) begin
                        rxd_d  = rx_shift_q;
                        rx_set = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Sticky flags: a set event on the same edge as a clearing read wins
    always_comb begin
        tx_done_d  = tx_done_set | (tx_done_q & ~rd_con);
        rx_ready_d = rx_set | (rx_ready_q & ~rd_rxd);
        con_ie_d   = wr_con ? wdata[1:0] : con_ie_q;
    end

    // State registers for both FSMs, bus-visible registers and synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 8'h00;
            tx_line_q  <= 1'b1;
            tx_done_q  <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rxd_q      <= 8'h00;
            rx_ready_q <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            con_ie_q   <= 2'b00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_line_q  <= tx_line_d;
            tx_done_q  <= tx_done_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rxd_q      <= rxd_d;
            rx_ready_q <= rx_ready_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            con_ie_q   <= con_ie_d;
        end
    end

`ifdef UART_PARITY_EN
    logic parity_err_q;

    // Sticky parity error, cleared by a CON read unless set on that edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= par_err_set | (parity_err_q & ~rd_con);
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Combinational read mux; zero when not selected
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            if (sel_txd) begin
                rdata = {24'h0, txd_q};
            end else if (sel_rxd) begin
                rdata = {24'h0, rxd_q};
            end else if (sel_con) begin
                rdata = {26'h0, parity_err, tx_busy, rx_ready_q, tx_done_q, con_ie_q};
            end
        end
    end

    assign irq          = (con_ie_q[0] & tx_done_q) | (con_ie_q[1] & rx_ready_q);
    assign uart_tx      = tx_line_q;
    assign dbg_tx_state = tx_state_q;
    assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed bench for uart_periph with BAUD_DIV = 16.
module tb_uart_periph;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          BAUD = 16;
    localparam logic [31:0] A_TXD = BASE + 32'h18;
    localparam logic [31:0] A_RXD = BASE + 32'h1C;
    localparam logic [31:0] A_CON = BASE + 32'h20;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        uart_rx;
    logic        uart_tx;
    logic [2:0]  dbg_tx_state;
    logic [2:0]  dbg_rx_state;

    int checks = 0;
    int errors = 0;

    uart_periph #(.BASE(BASE), .BAUD_DIV(BAUD)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .irq          (irq),
        .uart_rx      (uart_rx),
        .uart_tx      (uart_tx),
        .dbg_tx_state (dbg_tx_state),
        .dbg_rx_state (dbg_rx_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus drivers: strobes launched on negedge, take effect on the next posedge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0; addr = 32'h0;
    endtask

    // Serial driver for the RX line (stop_bit = 0 makes a framing error)
    task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        uart_rx = ^b;
        repeat (BAUD) @(negedge clk);
`endif
        uart_rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Follows a TX frame cycle by cycle right after the TXD write; reads CON
    // mid-frame and optionally attempts a second TXD write at cycle 40
    task automatic tx_wave(input logic [7:0] b, input bit inject);
        logic [10:0] exp_bits;
        logic        bad;
        logic        got;
        exp_bits    = 11'h7FF;
        exp_bits[0] = 1'b0;
        exp_bits[8:1] = b;
`ifdef UART_PARITY_EN
        exp_bits[9] = ^b;
`endif
        bad = 1'b0;
        got = 1'b1;
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL tx_pre_start: uart_tx=%0b expected 1", uart_tx);
        end
        for (int k = 1; k <= FRAME_BITS * BAUD; k++) begin
            @(negedge clk);
            if (uart_tx !== exp_bits[(k - 1) / BAUD] && !bad) begin
                bad = 1'b1;
                got = uart_tx;
            end
            if (k % BAUD == 0) begin
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL tx_bit%0d: uart_tx=%0b at some cycle, expected %0b",
                             (k - 1) / BAUD, got, exp_bits[(k - 1) / BAUD]);
                end
                bad = 1'b0;
            end
            if (k == 40 && inject) begin
                addr = A_TXD; wdata = 32'h33; wr = 1'b1;
            end
            if (k == 41) begin
                wr = 1'b0; wdata = 32'h0; addr = A_CON; rd = 1'b1;
                #1;
                checks++;
                if (rdata !== 32'h11) begin
                    errors++;
                    $display("FAIL tx_busy_con: CON=%h expected %h", rdata, 32'h11);
                end
            end
            if (k == 42) begin
                rd = 1'b0; addr = 32'h0;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: uart_tx=%0b irq=%0b expected 1/0", uart_tx, irq);
        end
        reset = 1'b1;
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_con: CON=%h expected 0", d); end
        bus_read(A_TXD, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_txd: TXD=%h expected 0", d); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_rxd: RXD=%h expected 0", d); end
        checks++;
        if (dbg_tx_state !== 3'd0 || dbg_rx_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_fsm: tx=%0d rx=%0d expected 0/0", dbg_tx_state, dbg_rx_state);
        end
    endtask

    task automatic test_tx_frame();
        logic [31:0] d;
        bus_write(A_CON, 32'h1);
        bus_write(A_TXD, 32'hA5);
        tx_wave(8'hA5, 1'b0);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq_set: irq=%0b expected 1", irq); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h05) begin errors++; $display("FAIL tx_con_done: CON=%h expected 05", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL tx_irq_clear: irq=%0b expected 0", irq); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL tx_con_cleared: CON=%h expected 01", d); end
        bus_read(A_TXD, d);
        checks++;
        if (d !== 32'hA5) begin errors++; $display("FAIL tx_txd_read: TXD=%h expected a5", d); end
    endtask

    task automatic test_tx_busy_write();
        logic [31:0] d;
        bus_write(A_TXD, 32'hA5);
        tx_wave(8'hA5, 1'b1);
        bus_read(A_TXD, d);
        checks++;
        if (d !== 32'hA5) begin errors++; $display("FAIL busy_txd: TXD=%h expected a5", d); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h05) begin errors++; $display("FAIL busy_con: CON=%h expected 05", d); end
        // The ignored write must not have queued a second frame
        repeat (20) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL busy_no_refire: uart_tx=%0b expected 1", uart_tx); end
    endtask

    task automatic test_rx_frame();
        logic [31:0] d;
        bus_write(A_CON, 32'h2);
        send_rx_frame(8'h3C, 1'b1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set: irq=%0b expected 1", irq); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL rx_data: RXD=%h expected 3c", d); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL rx_con_cleared: CON=%h expected 02", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: irq=%0b expected 0", irq); end
    endtask

    task automatic test_rx_false_start();
        logic [31:0] d;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL glitch_con: CON=%h expected 02", d); end
        checks++;
        if (dbg_rx_state !== 3'd0) begin errors++; $display("FAIL glitch_idle: rx state=%0d expected 0", dbg_rx_state); end
    endtask

    task automatic test_rx_framing_err();
        logic [31:0] d;
        send_rx_frame(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL frame_err_con: CON=%h expected 02", d); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL frame_err_rxd: RXD=%h expected 3c", d); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        bit seen;
        send_rx_frame(8'h11, 1'b1);
        send_rx_frame(8'h22, 1'b1);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0A) begin errors++; $display("FAIL overrun_con: CON=%h expected 0a", d); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL overrun_rxd: RXD=%h expected 22", d); end
        // Keep reading RXD every cycle; drop rd as soon as the new byte shows,
        // so the last read shares its edge with the stop-bit completion
        seen = 1'b0;
        fork
            send_rx_frame(8'h33, 1'b1);
            begin
                @(negedge clk);
                addr = A_RXD; rd = 1'b1;
                for (int n = 0; n < 400 && !seen; n++) begin
                    @(negedge clk);
                    if (rdata[7:0] === 8'h33) begin
                        rd = 1'b0; addr = 32'h0;
                        seen = 1'b1;
                    end
                end
                rd = 1'b0; addr = 32'h0;
            end
        join
        checks++;
        if (!seen) begin errors++; $display("FAIL coincide_timeout: RXD never showed 33 within 400 cycles"); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL coincide_irq: irq=%0b expected 1", irq); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0A) begin errors++; $display("FAIL coincide_con: CON=%h expected 0a", d); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h33) begin errors++; $display("FAIL coincide_rxd: RXD=%h expected 33", d); end
    endtask

    task automatic test_rd_wr_same();
        logic [31:0] d;
        @(negedge clk);
        addr = A_CON; wdata = 32'h1; rd = 1'b1; wr = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h02) begin errors++; $display("FAIL rdwr_rdata: rdata=%h expected 02", rdata); end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL rdwr_write: CON=%h expected 01", d); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        bus_write(BASE + 32'h19, 32'h77);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL decode_no_tx: CON=%h expected 01", d); end
        bus_read(32'h5000_0018, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL decode_upper: rdata=%h expected 0", d); end
        bus_read(BASE + 32'h19, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL decode_offset: rdata=%h expected 0", d); end
        @(negedge clk);
        addr = A_TXD;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL decode_no_rd: rdata=%h expected 0", rdata); end
        addr = 32'h0;
        bus_write(A_CON, 32'hFF);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL decode_con_ro: CON=%h expected 03", d); end
        checks++;
        if (uart_tx !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL decode_quiet: uart_tx=%0b irq=%0b expected 1/0", uart_tx, irq);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic        bad;
        bus_write(A_TXD, 32'h00);
        repeat (30) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL midrst_in_frame: uart_tx=%0b expected 0", uart_tx); end
        reset = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL midrst_async: uart_tx=%0b expected 1", uart_tx); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midrst_after: uart_tx went 0, expected 1"); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midrst_con: CON=%h expected 0", d); end
        checks++;
        if (dbg_tx_state !== 3'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midrst_fsm: tx state=%0d irq=%0b expected 0/0", dbg_tx_state, irq);
        end
    endtask

    initial begin
        reset   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 32'h0;
        wdata   = 32'h0;
        uart_rx = 1'b1;
        test_reset();
        test_tx_frame();
        test_tx_busy_write();
        test_rx_frame();
        test_rx_false_start();
        test_rx_framing_err();
        test_rx_overrun();
        test_rd_wr_same();
        test_decode();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
